// File: rtl/key_encoder_8to3.sv
// Key encoder: synchronises and debounces 8 raw keys, then reports the highest
// pressed key index with a valid/ack handshake and waits for full release.
module key_encoder_8to3 #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keys,
    input  logic       en,
    input  logic       ack,
    output logic [2:0] code,
    output logic       multi,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        REPORT,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       sync_meta;
    logic [7:0]       ks;
    logic [7:0]       snapshot;
    logic [7:0]       snapshot_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       code_next;
    logic             multi_next;
    logic             valid_next;
    logic [2:0]       snap_index;
    logic             snap_multi;

    // Highest set bit wins; clearing the lowest set bit leaves nonzero only if
    // at least two keys are down.
    always_comb begin
        snap_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (snapshot[i]) begin
                snap_index = 3'(i);
            end
        end
        snap_multi = (snapshot & (snapshot - 8'd1)) != 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 8'd0;
            ks        <= 8'd0;
            state     <= IDLE;
            snapshot  <= 8'd0;
            cnt       <= '0;
            code      <= 3'd0;
            multi     <= 1'b0;
            valid     <= 1'b0;
        end else begin
            sync_meta <= keys;
            ks        <= sync_meta;
            state     <= state_next;
            snapshot  <= snapshot_next;
            cnt       <= cnt_next;
            code      <= code_next;
            multi     <= multi_next;
            valid     <= valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        snapshot_next = snapshot;
        cnt_next      = cnt;
        code_next     = code;
        multi_next    = multi;
        valid_next    = valid;

        case (state)
            IDLE: begin
                if (en && ks != 8'd0) begin
                    state_next    = DEBOUNCE;
                    snapshot_next = ks;
                    cnt_next      = '0;
                end
            end

            DEBOUNCE: begin
                if (!en || ks == 8'd0) begin
                    state_next = IDLE;
                end else if (ks != snapshot) begin
                    snapshot_next = ks;
                    cnt_next      = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = REPORT;
                    code_next  = snap_index;
                    multi_next = snap_multi;
                    valid_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            // Code/Multi stay frozen here regardless of keys or enable.
            REPORT: begin
                if (valid && ack) begin
                    state_next = RELEASE;
                    valid_next = 1'b0;
                    cnt_next   = '0;
                end
            end

            RELEASE: begin
                if (ks != 8'd0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_encoder_8to3.sv
// Bench for key_encoder_8to3: directed handshake scenarios followed by random
// key/enable/ack traffic, all checked against a sample-counting reference model.
module tb_key_encoder_8to3;

    localparam int D = 4;

    localparam int MODE_IDLE     = 0;
    localparam int MODE_ARMING   = 1;
    localparam int MODE_SHOWING  = 2;
    localparam int MODE_DRAINING = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keys;
    logic       en;
    logic       ack;
    logic [2:0] code;
    logic       multi;
    logic       valid;
    logic       busy;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: keys seen through a two-sample delay, a behavioural mode,
    // and run lengths of identical (arming) or all-zero (draining) samples.
    logic [7:0] delay1 = 8'd0;
    logic [7:0] delay2 = 8'd0;
    int         mode = MODE_IDLE;
    logic [7:0] armedPattern = 8'd0;
    int         heldSamples = 0;
    int         quietSamples = 0;
    logic [2:0] expCode = 3'd0;
    logic       expMulti = 1'b0;
    logic       sawValid;

    key_encoder_8to3 #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(keys),
        .en(en),
        .ack(ack),
        .code(code),
        .multi(multi),
        .valid(valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] topKey(input logic [7:0] p);
        int highest;
        highest = (p == 8'd0) ? 0 : $clog2(int'(p) + 1) - 1;
        return 3'(highest);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs present before it.
    task automatic modelStep(input logic [7:0] k, input logic e, input logic a, input logic r);
        logic [7:0] seen;
        if (r) begin
            delay1   = 8'd0;
            delay2   = 8'd0;
            mode     = MODE_IDLE;
            expCode  = 3'd0;
            expMulti = 1'b0;
        end else begin
            seen = delay2;
            case (mode)
                MODE_IDLE: begin
                    if (e && seen != 8'd0) begin
                        mode         = MODE_ARMING;
                        armedPattern = seen;
                        heldSamples  = 1;
                    end
                end
                MODE_ARMING: begin
                    if (!e || seen == 8'd0) begin
                        mode = MODE_IDLE;
                    end else if (seen != armedPattern) begin
                        armedPattern = seen;
                        heldSamples  = 1;
                    end else begin
                        heldSamples++;
                        if (heldSamples == D + 1) begin
                            mode     = MODE_SHOWING;
                            expCode  = topKey(armedPattern);
                            expMulti = $countones(armedPattern) > 1;
                        end
                    end
                end
                MODE_SHOWING: begin
                    if (a) begin
                        mode         = MODE_DRAINING;
                        quietSamples = 0;
                    end
                end
                default: begin
                    quietSamples = (seen == 8'd0) ? quietSamples + 1 : 0;
                    if (quietSamples == D) mode = MODE_IDLE;
                end
            endcase
            delay2 = delay1;
            delay1 = k;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] k, input logic e, input logic a, input logic r);
        keys  = k;
        en    = e;
        ack   = a;
        reset = r;
        modelStep(k, e, a, r);
        @(posedge clk);
        #1;
        checkOutput("outputs", {2'b00, code, multi, valid, busy},
                    {2'b00, expCode, expMulti, mode == MODE_SHOWING, mode != MODE_IDLE});
    endtask

    task automatic drainKeys(input logic e);
        for (int c = 0; c < 8; c++) applyStimulus(8'h00, e, 1'b0, 1'b0);
        checkOutput("drained_busy", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        keys  = 8'h00;
        en    = 1'b0;
        ack   = 1'b0;
        reset = 1'b1;

        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_state", {2'b00, code, multi, valid, busy}, 8'h00);

        // Single key: exact report latency, then a long wait without ack.
        for (int c = 1; c <= D + 3; c++) begin
            applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
            if (c == D + 2) checkOutput("s2_valid_early", {7'd0, valid}, 8'd0);
        end
        checkOutput("s2_valid_on_time", {7'd0, valid}, 8'd1);
        checkOutput("s2_code", {5'd0, code}, 8'd3);
        checkOutput("s2_multi", {7'd0, multi}, 8'd0);
        for (int c = 0; c < 10; c++) applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
        checkOutput("s2_valid_held", {7'd0, valid}, 8'd1);
        checkOutput("s2_code_held", {5'd0, code}, 8'd3);
        applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_valid_after_ack", {7'd0, valid}, 8'd0);
        checkOutput("s2_busy_release", {7'd0, busy}, 8'd1);
        drainKeys(1'b1);

        // Two keys with ack held high from the start: the raising edge ignores ack.
        for (int c = 1; c <= D + 3; c++) applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
        checkOutput("s3_valid", {7'd0, valid}, 8'd1);
        checkOutput("s3_code", {5'd0, code}, 8'd7);
        checkOutput("s3_multi", {7'd0, multi}, 8'd1);
        applyStimulus(8'h81, 1'b1, 1'b1, 1'b0);
        checkOutput("s3_valid_dropped", {7'd0, valid}, 8'd0);
        sawValid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
            sawValid |= valid;
        end
        checkOutput("s3_no_second_valid", {7'd0, sawValid}, 8'd0);
        checkOutput("s3_busy_held", {7'd0, busy}, 8'd1);
        drainKeys(1'b1);

        // Glitch rejection, then a pattern change that restarts the debounce.
        sawValid = 1'b0;
        for (int c = 0; c < 2; c++) applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
            sawValid |= valid;
        end
        checkOutput("s4_glitch_no_valid", {7'd0, sawValid}, 8'd0);
        checkOutput("s4_glitch_idle", {7'd0, busy}, 8'd0);
        for (int c = 0; c < 4; c++) applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) applyStimulus(8'h10, 1'b1, 1'b0, 1'b0);
        checkOutput("s4_restart_not_yet", {7'd0, valid}, 8'd0);
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0);
        checkOutput("s4_restart_valid", {7'd0, valid}, 8'd1);
        checkOutput("s4_restart_code", {5'd0, code}, 8'd4);
        applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
        drainKeys(1'b1);

        // Enable gating: idle, mid-debounce abort, and no effect during report.
        sawValid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
            sawValid |= valid | busy;
        end
        checkOutput("s5_disabled_quiet", {7'd0, sawValid}, 8'd0);
        for (int c = 0; c < 2; c++) applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
        checkOutput("s5_debouncing", {7'd0, busy}, 8'd1);
        applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_abort_idle", {7'd0, busy}, 8'd0);
        for (int c = 0; c < 8; c++) applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
        checkOutput("s5_valid", {7'd0, valid}, 8'd1);
        checkOutput("s5_code", {5'd0, code}, 8'd1);
        for (int c = 0; c < 5; c++) applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_valid_en_low", {7'd0, valid}, 8'd1);
        applyStimulus(8'h02, 1'b0, 1'b1, 1'b0);
        checkOutput("s5_ack_en_low", {7'd0, valid}, 8'd0);
        drainKeys(1'b0);

        // Bouncing release keeps the encoder waiting; a clean release frees it.
        for (int c = 0; c < D + 3; c++) applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_code", {5'd0, code}, 8'd0);
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 16; c++) applyStimulus(((c / 2) % 2 == 1) ? 8'h01 : 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_still_release", {7'd0, busy}, 8'd1);
        for (int c = 0; c < 5; c++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_release_not_yet", {7'd0, busy}, 8'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_release_idle", {7'd0, busy}, 8'd0);
        for (int c = 0; c < D + 3; c++) applyStimulus(8'h20, 1'b1, 1'b0, 1'b0);
        checkOutput("s6_next_valid", {7'd0, valid}, 8'd1);
        checkOutput("s6_next_code", {5'd0, code}, 8'd5);
        applyStimulus(8'h20, 1'b1, 1'b1, 1'b0);
        drainKeys(1'b1);

        // Reset during an outstanding report clears everything at once.
        for (int c = 0; c < D + 3; c++) applyStimulus(8'h26, 1'b1, 1'b0, 1'b0);
        checkOutput("s1_pre_valid", {7'd0, valid}, 8'd1);
        checkOutput("s1_pre_code", {2'b00, code, multi, 2'b00}, {2'b00, 3'd5, 1'b1, 2'b00});
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("s1_reset_clears", {2'b00, code, multi, valid, busy}, 8'h00);

        // Random bursts of held patterns with random enable, ack and rare reset.
        for (int burst = 0; burst < 400; burst++) begin
            logic [7:0] pat;
            int         len;
            pat = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                applyStimulus(pat, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 199) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
